// File: rtl/serial_sub_defs.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
package serial_sub_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational so it can be reused by ripple subtractors.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b) with valid/ready handshakes.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow_out
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    full_subtractor u_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Result bits shift into the vacated MSB end of r_sa, so the visible diff
    // keeps the previous result until the last bit lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_sa  <= {w_d, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_bin <= w_bout;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff   <= {w_d, r_sa[WIDTH-1:1]};
                        r_borrow <= w_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        r_ovf    <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results are queued
// at operand acceptance and popped when out_valid appears.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a_i),
        .b          (b_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .ovf        (ovf),
`endif
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents operands, queues the expected result, returns #1 after acceptance.
    task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   k;
        e.d  = x - y;
        e.bo = (x < y);
        e.ov = (x[W-1] ^ y[W-1]) & (x[W-1] ^ e.d[W-1]);
        sb_q.push_back(e);
        a_i      = x;
        b_i      = y;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            $display("FAIL accept_wait: in_ready=%b, required 1 within 50 cycles", in_ready);
            n_err++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; reports latency, whether in_ready was seen high and
    // whether diff changed while no result was valid.
    task automatic wait_out(output int lat, output bit rdy_seen, output bit moved);
        logic [W-1:0] d0;
        d0       = diff;
        lat      = 0;
        rdy_seen = 1'b0;
        moved    = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) rdy_seen = 1'b1;
            if (!out_valid && diff !== d0) moved = 1'b1;
        end while (!out_valid && lat < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_i = '0; b_i = '0;
        #1;
        n_vec += 4;
        if (in_ready !== 1'b1)   begin $display("FAIL reset_in_ready: got %b want 1", in_ready); n_err++; end
        if (out_valid !== 1'b0)  begin $display("FAIL reset_out_valid: got %b want 0", out_valid); n_err++; end
        if (diff !== 8'h00)      begin $display("FAIL reset_diff: got %h want 00", diff); n_err++; end
        if (borrow_out !== 1'b0) begin $display("FAIL reset_borrow: got %b want 0", borrow_out); n_err++; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_vec += 2;
        if (in_ready !== 1'b1)  begin $display("FAIL post_reset_in_ready: got %b want 1", in_ready); n_err++; end
        if (out_valid !== 1'b0) begin $display("FAIL post_reset_out_valid: got %b want 0", out_valid); n_err++; end
    endtask

    task automatic test_basic();
        logic [W-1:0] av[2] = '{8'h0A, 8'h03};
        logic [W-1:0] bv[2] = '{8'h03, 8'h0A};
        int   lat;
        bit   rdy_seen, moved;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_op(av[i], bv[i]);
            wait_out(lat, rdy_seen, moved);
            e = sb_q.pop_front();
            n_vec += 6;
            if (lat !== W)         begin $display("FAIL basic%0d_latency: got %0d want %0d", i, lat, W); n_err++; end
            if (diff !== e.d)      begin $display("FAIL basic%0d_diff: got %h want %h", i, diff, e.d); n_err++; end
            if (borrow_out !== e.bo) begin $display("FAIL basic%0d_borrow: got %b want %b", i, borrow_out, e.bo); n_err++; end
            if (rdy_seen)          begin $display("FAIL basic%0d_in_ready_busy: got 1 want 0", i); n_err++; end
            if (moved)             begin $display("FAIL basic%0d_diff_during_run: got changed want held", i); n_err++; end
            @(posedge clk); #1;
            if (out_valid !== 1'b0) begin $display("FAIL basic%0d_handoff: out_valid=%b want 0", i, out_valid); n_err++; end
            $display("basic%0d: %h - %h -> diff=%h borrow=%b lat=%0d", i, av[i], bv[i], diff, borrow_out, lat);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   rdy_seen, moved;
        exp_t e;
        time  t0, t1;
        out_ready = 1'b1;
        drive_op(8'h00, 8'h00);
        t0 = $time;
        wait_out(lat, rdy_seen, moved);
        e = sb_q.pop_front();
        n_vec += 3;
        if (diff !== e.d)        begin $display("FAIL b2b0_diff: got %h want %h", diff, e.d); n_err++; end
        if (borrow_out !== e.bo) begin $display("FAIL b2b0_borrow: got %b want %b", borrow_out, e.bo); n_err++; end
        if (rdy_seen)            begin $display("FAIL b2b0_in_ready_busy: got 1 want 0"); n_err++; end
        $display("b2b0: 00 - 00 -> diff=%h borrow=%b", diff, borrow_out);
        @(posedge clk); #1;
        drive_op(8'hFF, 8'h01);
        t1 = $time;
        n_vec++;
        if ((t1 - t0) / 10 != W + 2) begin $display("FAIL b2b_throughput: got %0d cycles want %0d", (t1 - t0) / 10, W + 2); n_err++; end
        wait_out(lat, rdy_seen, moved);
        e = sb_q.pop_front();
        n_vec += 4;
        if (diff !== e.d)        begin $display("FAIL b2b1_diff: got %h want %h", diff, e.d); n_err++; end
        if (borrow_out !== e.bo) begin $display("FAIL b2b1_borrow: got %b want %b", borrow_out, e.bo); n_err++; end
        if (rdy_seen)            begin $display("FAIL b2b1_in_ready_busy: got 1 want 0"); n_err++; end
        if (lat !== W)           begin $display("FAIL b2b1_latency: got %0d want %0d", lat, W); n_err++; end
        $display("b2b1: ff - 01 -> diff=%h borrow=%b", diff, borrow_out);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int   lat;
        bit   rdy_seen, moved;
        bit   seen_valid;
        exp_t e;
        out_ready = 1'b0;
        drive_op(8'h3C, 8'h5A);
        wait_out(lat, rdy_seen, moved);
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            a_i      = W'($urandom);
            b_i      = W'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
            n_vec += 4;
            if (out_valid !== 1'b1)  begin $display("FAIL bp%0d_out_valid: got %b want 1", i, out_valid); n_err++; end
            if (diff !== e.d)        begin $display("FAIL bp%0d_diff: got %h want %h", i, diff, e.d); n_err++; end
            if (borrow_out !== e.bo) begin $display("FAIL bp%0d_borrow: got %b want %b", i, borrow_out, e.bo); n_err++; end
            if (in_ready !== 1'b0)   begin $display("FAIL bp%0d_in_ready: got %b want 0", i, in_ready); n_err++; end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec += 2;
        if (out_valid !== 1'b0) begin $display("FAIL bp_handoff_valid: got %b want 0", out_valid); n_err++; end
        if (in_ready !== 1'b1)  begin $display("FAIL bp_handoff_ready: got %b want 1", in_ready); n_err++; end
        seen_valid = 1'b0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        n_vec++;
        if (seen_valid) begin $display("FAIL bp_ghost_result: out_valid seen 1 want 0"); n_err++; end
        $display("backpressure: 3c - 5a -> diff=%h borrow=%b held 5 cycles", e.d, e.bo);
    endtask

    task automatic test_async_reset();
        int   lat;
        bit   rdy_seen, moved;
        bit   seen_valid;
        exp_t e;
        out_ready = 1'b1;
        drive_op(8'hC3, 8'h11);
        void'(sb_q.pop_back());
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec += 4;
        if (out_valid !== 1'b0)  begin $display("FAIL arst_out_valid: got %b want 0", out_valid); n_err++; end
        if (in_ready !== 1'b1)   begin $display("FAIL arst_in_ready: got %b want 1", in_ready); n_err++; end
        if (diff !== 8'h00)      begin $display("FAIL arst_diff: got %h want 00", diff); n_err++; end
        if (borrow_out !== 1'b0) begin $display("FAIL arst_borrow: got %b want 0", borrow_out); n_err++; end
        #2 rst = 1'b0;
        seen_valid = 1'b0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        n_vec++;
        if (seen_valid) begin $display("FAIL arst_no_result: out_valid seen 1 want 0"); n_err++; end
        drive_op(8'h55, 8'h22);
        wait_out(lat, rdy_seen, moved);
        e = sb_q.pop_front();
        n_vec += 2;
        if (diff !== e.d)        begin $display("FAIL arst_next_diff: got %h want %h", diff, e.d); n_err++; end
        if (borrow_out !== e.bo) begin $display("FAIL arst_next_borrow: got %b want %b", borrow_out, e.bo); n_err++; end
        $display("async_reset: aborted c3-11, then 55 - 22 -> diff=%h borrow=%b", diff, borrow_out);
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] av[3] = '{8'h80, 8'h05, 8'h7F};
        logic [W-1:0] bv[3] = '{8'h01, 8'h03, 8'hFF};
        int   lat;
        bit   rdy_seen, moved;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(av[i], bv[i]);
            wait_out(lat, rdy_seen, moved);
            e = sb_q.pop_front();
            n_vec += 3;
            if (diff !== e.d)        begin $display("FAIL ovf%0d_diff: got %h want %h", i, diff, e.d); n_err++; end
            if (borrow_out !== e.bo) begin $display("FAIL ovf%0d_borrow: got %b want %b", i, borrow_out, e.bo); n_err++; end
            if (ovf !== e.ov)        begin $display("FAIL ovf%0d_ovf: got %b want %b", i, ovf, e.ov); n_err++; end
            $display("ovf%0d: %h - %h -> diff=%h borrow=%b ovf=%b", i, av[i], bv[i], diff, borrow_out, ovf);
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
